partial_prod_gen: RTL and testbench

Upstream stage of adder_16 in the 16x16 unsigned multiplier path. It accepts a 16-bit operand pair through a valid/ready handshake and time-multiplexes a single 8x8 multiplier over four cycles. It produces the four 16-bit partial products that adder_16 sums into PROD, and holds them stable, with out_valid asserted, until the consumer takes them.

---
 rtl/mult_pkg.sv | 20 ++
 rtl/mult_8x8.sv | 12 +
 rtl/partial_prod_gen.sv | 120 ++++++++++++
 tb/tb_partial_prod_gen.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the 16x16 multiplier partial-product path.
package mult_pkg;

  localparam int OP_W   = 16;
  localparam int BYTE_W = 8;

  // Byte-pair select: bit 0 picks the op_a byte, bit 1 picks the op_b byte.
  localparam logic [1:0] SEL_LL = 2'd0;
  localparam logic [1:0] SEL_HL = 2'd1;
  localparam logic [1:0] SEL_LH = 2'd2;
  localparam logic [1:0] SEL_HH = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mult_8x8.sv
// Combinational 8x8 unsigned multiplier, full 16-bit result.
module mult_8x8
  import mult_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  output logic [OP_W-1:0]   p
);

  assign p = {{(OP_W-BYTE_W){1'b0}}, a} * {{(OP_W-BYTE_W){1'b0}}, b};

endmodule

// File: rtl/partial_prod_gen.sv
// Four-cycle time-multiplexed 8x8 partial-product generator; results held with
// out_valid until out_ready, new operands accepted in IDLE or on the DONE handshake.
module partial_prod_gen
  import mult_pkg::*;
#(
  parameter int unsigned MUL_REG = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] op_a,
  input  logic [OP_W-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] prod1,
  output logic [OP_W-1:0] prod2,
  output logic [OP_W-1:0] prod3,
  output logic [OP_W-1:0] prod4,
  output logic            busy
);

  state_t              state, state_nxt;
  logic [1:0]          cnt;
  logic [OP_W-1:0]     op_a_q, op_b_q;
  logic [BYTE_W-1:0]   a_byte, b_byte;
  logic [OP_W-1:0]     mul_out;
  logic                accept;
  logic                wr_en;
  logic [1:0]          wr_sel;
  logic [OP_W-1:0]     wr_dat;

  assign in_ready  = !rst && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

  assign a_byte = cnt[0] ? op_a_q[OP_W-1:BYTE_W] : op_a_q[BYTE_W-1:0];
  assign b_byte = cnt[1] ? op_b_q[OP_W-1:BYTE_W] : op_b_q[BYTE_W-1:0];

  mult_8x8 u_mult (
    .a (a_byte),
    .b (b_byte),
    .p (mul_out)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_MUL;
      ST_MUL:   if (cnt == SEL_HH) state_nxt = (MUL_REG != 0) ? ST_DRAIN : ST_DONE;
      ST_DRAIN: state_nxt = ST_DONE;
      ST_DONE:  if (out_ready) state_nxt = accept ? ST_MUL : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= SEL_LL;
      op_a_q <= '0;
      op_b_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_a_q <= op_a;
        op_b_q <= op_b;
        cnt    <= SEL_LL;
      end else if (state == ST_MUL) begin
        cnt <= cnt + 2'd1;
      end
    end
  end

  // Registered variant writes each product one edge after it is formed;
  // DRAIN covers the write of the last (high x high) product.
  if (MUL_REG != 0) begin : g_mul_reg
    logic [OP_W-1:0] mul_q;
    logic [1:0]      sel_q;
    logic            wr_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        mul_q <= '0;
        sel_q <= SEL_LL;
        wr_q  <= 1'b0;
      end else begin
        mul_q <= mul_out;
        sel_q <= cnt;
        wr_q  <= (state == ST_MUL);
      end
    end

    assign wr_en  = wr_q;
    assign wr_sel = sel_q;
    assign wr_dat = mul_q;
  end else begin : g_mul_direct
    assign wr_en  = (state == ST_MUL);
    assign wr_sel = cnt;
    assign wr_dat = mul_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod1 <= '0;
      prod2 <= '0;
      prod3 <= '0;
      prod4 <= '0;
    end else if (wr_en) begin
      case (wr_sel)
        SEL_LL:  prod1 <= wr_dat;
        SEL_HL:  prod2 <= wr_dat;
        SEL_LH:  prod3 <= wr_dat;
        default: prod4 <= wr_dat;
      endcase
    end
  end

endmodule

// File: tb/tb_partial_prod_gen.sv
// Directed bench: instance 0 has MUL_REG=0, instance 1 has MUL_REG=1.
module tb_partial_prod_gen;

  logic        clk = 1'b0;
  logic        rst       [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [15:0] op_a      [2];
  logic [15:0] op_b      [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [15:0] p1        [2];
  logic [15:0] p2        [2];
  logic [15:0] p3        [2];
  logic [15:0] p4        [2];
  logic        busy      [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  partial_prod_gen #(.MUL_REG(0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .op_a(op_a[0]), .op_b(op_b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .prod1(p1[0]), .prod2(p2[0]), .prod3(p3[0]), .prod4(p4[0]), .busy(busy[0])
  );

  partial_prod_gen #(.MUL_REG(1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .op_a(op_a[1]), .op_b(op_b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .prod1(p1[1]), .prod2(p2[1]), .prod3(p3[1]), .prod4(p4[1]), .busy(busy[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept an operand pair on instance d (leaves in_valid low afterwards).
  task automatic send(input int d, input logic [15:0] a, input logic [15:0] b, input string tag);
    in_valid[d] = 1'b1;
    op_a[d]     = a;
    op_b[d]     = b;
    check({tag, " in_ready"}, {31'd0, in_ready[d]}, 32'd1);
    tick();
    in_valid[d] = 1'b0;
  endtask

  // Count cycles from the accept edge until out_valid, bounded.
  task automatic wait_out(input int d, input int exp_lat, input string tag);
    int lat = 0;
    while (!out_valid[d] && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
  endtask

  task automatic check_prods(input int d, input logic [15:0] e1, input logic [15:0] e2,
                             input logic [15:0] e3, input logic [15:0] e4,
                             input logic [31:0] eprod, input string tag);
    logic [31:0] sum;
    check({tag, " prod1"}, {16'd0, p1[d]}, {16'd0, e1});
    check({tag, " prod2"}, {16'd0, p2[d]}, {16'd0, e2});
    check({tag, " prod3"}, {16'd0, p3[d]}, {16'd0, e3});
    check({tag, " prod4"}, {16'd0, p4[d]}, {16'd0, e4});
    sum = {16'd0, p1[d]} + ({16'd0, p2[d]} << 8) + ({16'd0, p3[d]} << 8) + ({16'd0, p4[d]} << 16);
    check({tag, " PROD"}, sum, eprod);
  endtask

  task automatic consume(input int d, input string tag);
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
    check({tag, " out_valid falls"}, {31'd0, out_valid[d]}, 32'd0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; in_valid[d] = 1'b0; out_ready[d] = 1'b0;
      op_a[d] = 16'h0; op_b[d] = 16'h0;
    end
    tick();
    tick();
    check("in_ready during rst", {31'd0, in_ready[0]}, 32'd0);
    rst[0] = 1'b0; rst[1] = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset out_valid", {31'd0, out_valid[d]}, 32'd0);
      check("reset busy", {31'd0, busy[d]}, 32'd0);
      check("reset in_ready", {31'd0, in_ready[d]}, 32'd1);
      check_prods(d, 16'h0, 16'h0, 16'h0, 16'h0, 32'h0, "reset");
    end

    // Basic operation, unregistered multiplier
    send(0, 16'h1234, 16'h5678, "t1");
    wait_out(0, 4, "t1");
    check_prods(0, 16'h1860, 16'h0870, 16'h1178, 16'h060C, 32'h06260060, "t1");
    consume(0, "t1");

    // All-ones with registered multiplier, then hold in DONE
    send(1, 16'hFFFF, 16'hFFFF, "t2");
    wait_out(1, 5, "t2");
    check_prods(1, 16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01, 32'hFFFE0001, "t2");
    in_valid[1] = 1'b1;
    op_a[1] = 16'h1111; op_b[1] = 16'h2222;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold out_valid", {31'd0, out_valid[1]}, 32'd1);
      check("hold in_ready", {31'd0, in_ready[1]}, 32'd0);
      check("hold prod1", {16'd0, p1[1]}, 32'h0000FE01);
      check("hold prod4", {16'd0, p4[1]}, 32'h0000FE01);
    end
    in_valid[1] = 1'b0;
    consume(1, "t2");
    check("t2 idle after consume", {31'd0, busy[1]}, 32'd0);

    send(1, 16'h0000, 16'hABCD, "t3");
    wait_out(1, 5, "t3");
    check_prods(1, 16'h0, 16'h0, 16'h0, 16'h0, 32'h0, "t3");
    consume(1, "t3");

    // Back-to-back with both handshakes held high
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    op_a[0] = 16'h0102; op_b[0] = 16'h0304;
    check("b2b in_ready", {31'd0, in_ready[0]}, 32'd1);
    tick();
    op_a[0] = 16'h00FF; op_b[0] = 16'h0100;
    wait_out(0, 4, "b2b first");
    check_prods(0, 16'h0008, 16'h0004, 16'h0006, 16'h0003, 32'h00030A08, "b2b first");
    check("b2b in_ready at DONE", {31'd0, in_ready[0]}, 32'd1);
    tick();
    in_valid[0] = 1'b0;
    check("b2b out_valid after hs", {31'd0, out_valid[0]}, 32'd0);
    check("b2b busy no idle", {31'd0, busy[0]}, 32'd1);
    wait_out(0, 4, "b2b second");
    check_prods(0, 16'h0000, 16'h0000, 16'h00FF, 16'h0000, 32'h0000FF00, "b2b second");
    tick();
    out_ready[0] = 1'b0;
    check("b2b end idle", {31'd0, busy[0]}, 32'd0);

    // Reset in the second MUL cycle
    send(0, 16'h1234, 16'h5678, "rst");
    tick();
    rst[0] = 1'b1;
    #1;
    check("in_ready while rst", {31'd0, in_ready[0]}, 32'd0);
    tick();
    rst[0] = 1'b0;
    #1;
    check("rst out_valid", {31'd0, out_valid[0]}, 32'd0);
    check("rst busy", {31'd0, busy[0]}, 32'd0);
    check("rst in_ready", {31'd0, in_ready[0]}, 32'd1);
    check_prods(0, 16'h0, 16'h0, 16'h0, 16'h0, 32'h0, "rst");
    begin
      int seen = 0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (out_valid[0]) seen++;
      end
      check("rst no stale result", seen, 0);
    end

    // Operands wiggling after acceptance have no effect
    send(1, 16'h1234, 16'h5678, "wiggle");
    begin
      int lat = 0;
      while (!out_valid[1] && lat < 20) begin
        op_a[1] = 16'($urandom);
        op_b[1] = 16'($urandom);
        tick();
        lat++;
      end
      check("wiggle latency", lat, 5);
    end
    check_prods(1, 16'h1860, 16'h0870, 16'h1178, 16'h060C, 32'h06260060, "wiggle");
    consume(1, "wiggle");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
